// File: rtl/cdb_pkg.sv
// Shared definitions for the common-data-bus arbiter: source encodings,
// the empty-tag value and the default result/tag widths.
package cdb_pkg;

    localparam int CDB_TAG_W  = 3;
    localparam int CDB_DATA_W = 32;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_MEM = 1'b1;

    localparam logic [CDB_TAG_W-1:0] TAG_NONE = {CDB_TAG_W{1'b0}};

    typedef struct packed {
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_fifo.sv
// Small circular result FIFO; occupancy count is the only full/empty indicator.
// Flush empties it unconditionally, en=0 freezes it.
module cdb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 35,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s, do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1'b1);
        end
    endfunction

    // Next-state for pointers and occupancy
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        do_push_s = 1'b0;
        do_pop_s  = 1'b0;
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else if (en) begin
            do_push_s = push && (count_q < CNT_W'(DEPTH));
            do_pop_s  = pop && (count_q != {CNT_W{1'b0}});
            if (do_push_s) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (do_push_s && !do_pop_s) begin
                count_d = count_q + CNT_W'(1'b1);
            end else if (do_pop_s && !do_push_s) begin
                count_d = count_q - CNT_W'(1'b1);
            end else begin
                count_d = count_q;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Pointer, count and storage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= din;
            end
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: two source FIFOs feeding one registered broadcast per cycle.
// Define CDB_RR_EN for round-robin tie-breaking; otherwise memory wins ties.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int DATA_W     = CDB_DATA_W,
    parameter int TAG_W      = CDB_TAG_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            pause,
    input  logic                            flush,
    input  logic                            alu_valid,
    input  logic [TAG_W-1:0]                alu_tag,
    input  logic [DATA_W-1:0]               alu_data,
    output logic                            alu_ready,
    input  logic                            mem_valid,
    input  logic [TAG_W-1:0]                mem_tag,
    input  logic [DATA_W-1:0]               mem_data,
    output logic                            mem_ready,
    output logic                            cdb_valid,
    output logic [TAG_W-1:0]                cdb_tag,
    output logic [DATA_W-1:0]               cdb_data,
    output logic                            cdb_src,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] alu_cnt,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] mem_cnt
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = TAG_W + DATA_W;

    logic [ENT_W-1:0]  alu_head_s, mem_head_s, win_head_s;
    logic [CNT_W-1:0]  alu_cnt_s, mem_cnt_s;
    logic              alu_push_s, mem_push_s, alu_pop_s, mem_pop_s;
    logic              alu_ne_s, mem_ne_s, grant_any_s, grant_mem_s, advance_s;
    logic              cdb_valid_q, cdb_valid_d, cdb_src_q, cdb_src_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;

    assign alu_ready = (alu_cnt_s < CNT_W'(FIFO_DEPTH)) && !pause;
    assign mem_ready = (mem_cnt_s < CNT_W'(FIFO_DEPTH)) && !pause;

    // Tag-0 results complete the handshake but are never stored
    assign alu_push_s = alu_valid && alu_ready && !flush && (alu_tag != {TAG_W{1'b0}});
    assign mem_push_s = mem_valid && mem_ready && !flush && (mem_tag != {TAG_W{1'b0}});

    assign alu_ne_s    = (alu_cnt_s != {CNT_W{1'b0}});
    assign mem_ne_s    = (mem_cnt_s != {CNT_W{1'b0}});
    assign grant_any_s = alu_ne_s || mem_ne_s;
    assign advance_s   = !pause && !flush;
    assign alu_pop_s   = advance_s && grant_any_s && !grant_mem_s;
    assign mem_pop_s   = advance_s && grant_any_s && grant_mem_s;
    assign win_head_s  = grant_mem_s ? mem_head_s : alu_head_s;

    cdb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENT_W), .CNT_W(CNT_W)) u_alu_fifo (
        .clk(clk), .rst_n(rst), .en(!pause), .flush(flush),
        .push(alu_push_s), .pop(alu_pop_s), .din({alu_tag, alu_data}),
        .dout(alu_head_s), .count(alu_cnt_s)
    );

    cdb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENT_W), .CNT_W(CNT_W)) u_mem_fifo (
        .clk(clk), .rst_n(rst), .en(!pause), .flush(flush),
        .push(mem_push_s), .pop(mem_pop_s), .din({mem_tag, mem_data}),
        .dout(mem_head_s), .count(mem_cnt_s)
    );

`ifdef CDB_RR_EN
    logic last_grant_q, last_grant_d;

    // Tie-break: grant the source that did not win last time
    always_comb begin
        if (alu_ne_s && mem_ne_s) begin
            grant_mem_s = (last_grant_q == SRC_ALU);
        end else begin
            grant_mem_s = mem_ne_s;
        end
    end

    // last_grant moves only on an actual grant; flush leaves it alone
    always_comb begin
        last_grant_d = last_grant_q;
        if (advance_s && grant_any_s) begin
            last_grant_d = grant_mem_s;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Round-robin history register; reset favours ALU on the first tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= SRC_MEM;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    // Fixed priority: memory wins whenever it has an entry
    always_comb begin
        if (alu_ne_s && mem_ne_s) begin
            grant_mem_s = SRC_MEM;
        end else begin
            grant_mem_s = mem_ne_s;
        end
    end
`endif

    // Broadcast register next-state; data and source hold when idle
    always_comb begin
        cdb_valid_d = cdb_valid_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_src_d   = cdb_src_q;
        if (flush) begin
            cdb_valid_d = 1'b0;
            cdb_tag_d   = {TAG_W{1'b0}};
        end else if (pause) begin
            cdb_valid_d = cdb_valid_q;
        end else if (grant_any_s) begin
            cdb_valid_d = 1'b1;
            cdb_tag_d   = win_head_s[ENT_W-1 -: TAG_W];
            cdb_data_d  = win_head_s[DATA_W-1:0];
            cdb_src_d   = grant_mem_s;
        end else begin
            cdb_valid_d = 1'b0;
            cdb_tag_d   = {TAG_W{1'b0}};
        end
    end

    // Registered CDB outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= {TAG_W{1'b0}};
            cdb_data_q  <= {DATA_W{1'b0}};
            cdb_src_q   <= SRC_ALU;
        end else begin
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_src   = cdb_src_q;
    assign alu_cnt   = alu_cnt_s;
    assign mem_cnt   = mem_cnt_s;

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter between the ALU and the memory unit. Accepts completed results (ROB tag + 32-bit value) from both producers over valid/ready handshakes, buffers them in one small FIFO per source, and broadcasts one result per cycle on a single registered CDB. The CDB feeds the reservation stations, register status table and ROB wake-up logic.

## Interface
Parameters:
- DATA_W, 32, result width
- TAG_W, 3, ROB tag width; tag 0 means "no producer"
- FIFO_DEPTH, 2, entries per source FIFO (≥1)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- pause  in  1  global stall; freezes all state
- flush  in  1  mispredict clear; synchronous
- alu_valid  in  1  ALU result offered
- alu_tag  in  TAG_W  ALU destination tag
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU FIFO can accept
- mem_valid  in  1  memory result offered
- mem_tag  in  TAG_W  memory destination tag
- mem_data  in  DATA_W  load result
- mem_ready  out  1  memory FIFO can accept
- cdb_valid  out  1  broadcast this cycle
- cdb_tag  out  TAG_W  broadcast tag; 0 when cdb_valid=0
- cdb_data  out  DATA_W  broadcast value
- cdb_src  out  1  0=ALU, 1=memory
- alu_cnt, mem_cnt  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy

## Operation
- Push: on rising edge with x_valid && x_ready && !pause && !flush, entry {tag,data} written to FIFO tail.
- Tag 0 inputs: handshake completes (ready honoured), entry discarded, count unchanged.
- x_ready = (count < FIFO_DEPTH) && !pause; combinational from registered count. No push-when-full even if same-cycle pop.
- Arbitration each non-paused edge: candidates = non-empty FIFO heads. One candidate → granted. Two → policy per Configuration. Granted head popped, registered to cdb_* with cdb_valid=1.
- No candidate → cdb_valid=0, cdb_tag=0, cdb_data and cdb_src hold.
- Simultaneous push and pop on same FIFO (not full): both occur, count unchanged.
- Flush: both FIFOs emptied, cdb_valid=0/cdb_tag=0 next edge, same-cycle inputs dropped, last_grant kept. Flush overrides pause.
- Pause (no flush): FIFOs, counts, last_grant and all cdb_* registers hold value; consumers are paused in the same cycle so a held cdb_valid is not a duplicate broadcast.
- Reset (async, any time including mid-burst): FIFOs empty, counts 0, cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, last_grant=1 (memory), so first tie goes to ALU.

## Timing
- Input accepted at edge E → earliest broadcast registered at edge E+1, valid for the cycle after E+1. No input-to-CDB combinational path.
- Throughput: one broadcast per cycle total; each source sustains one per cycle when the other is idle.
- FIFO pointers wrap modulo FIFO_DEPTH; count is the sole full/empty source.
- cdb_valid is a one-cycle pulse per entry unless pause holds it.

## Configuration
- CDB_RR_EN defined: round-robin on ties; grant goes to source ≠ last_grant; last_grant updates only on a grant. Both sources continuously full → strict alternation ALU, MEM, ALU, ...
- CDB_RR_EN undefined: fixed priority, memory always wins ties; last_grant register not built. ALU can starve under continuous memory traffic (accepted).

## Structure
- cdb_pkg: SRC_ALU=1'b0, SRC_MEM=1'b1, TAG_NONE='0, default TAG_W/DATA_W localparams, cdb entry struct {tag,data}.
- Sub-module cdb_fifo (parameterised depth/width, push/pop/count, flush, async active-low reset) instanced twice; arbiter and output register in cdb_arbiter.

## Test plan
- Reset mid-traffic: both FIFOs holding 2 entries, drop rst → cdb_valid=0, cdb_tag=0, alu_cnt=mem_cnt=0 immediately; release → alu_ready=mem_ready=1.
- Single ALU push tag 3 data 0x1234 at edge E → cdb_valid=1, cdb_tag=3, cdb_data=0x1234, cdb_src=0 after edge E+1; idle (tag 0) after E+2.
- Both sources push every cycle, tags ALU 1,2 / MEM 4,5: with CDB_RR_EN → order 1,4,2,5; without → 4,5,1,2; ready drops when count=2.
- Tag-0 push on ALU with alu_valid=1 → alu_ready=1, alu_cnt stays 0, no broadcast.
- Pause for 3 cycles with broadcast tag 2 in flight and mem_cnt=1 → cdb_tag stays 2, counts hold, readies 0; after release next broadcast is the memory head.
- Flush with pause=1 and both FIFOs full → next edge counts 0, cdb_valid=0; same-cycle alu_valid tag 6 never broadcast.
